// File: rtl/bitstream_load_sequencer.sv
// Walks NUM_TILES tiles: start reader, wait for its word, write it to the tile config slot.
// Optional TLAST_CHECK_EN adds beat counting and tlast framing checks with an ERROR state.
module bitstream_load_sequencer #(
   parameter int NUM_TILES  = 4,
   parameter int TILE_CFG_W = 8,
   localparam int TILE_W    = (NUM_TILES <= 1) ? 1 : $clog2(NUM_TILES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  abort,
   output logic                  reader_start,
   input  logic                  reader_ready,
   input  logic [TILE_CFG_W-1:0] reader_bits,
   input  logic                  mon_tvalid,
   input  logic                  mon_tready,
   input  logic                  mon_tlast,
   output logic                  cfg_we,
   output logic [TILE_W-1:0]     cfg_addr,
   output logic [TILE_CFG_W-1:0] cfg_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT, S_WRITE, S_DONE, S_ERROR
   } state_t;

   localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

   state_t                  state_reg, state_next;
   logic [TILE_W-1:0]       tile_idx_reg, tile_idx_next;
   logic [TILE_W-1:0]       cfg_addr_reg, cfg_addr_next;
   logic [TILE_CFG_W-1:0]   cfg_data_reg, cfg_data_next;
   logic                    busy_w;
   logic                    idle_like;
   logic                    frame_err;

   assign busy_w    = (state_reg == S_START) || (state_reg == S_WAIT) || (state_reg == S_WRITE);
   assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERROR);

`ifdef TLAST_CHECK_EN
   localparam int EXP_BEATS = NUM_TILES * TILE_CFG_W;
   localparam int BEAT_W    = $clog2(EXP_BEATS + 1);
   localparam logic [BEAT_W:0] EXP_NUM = (BEAT_W + 1)'(EXP_BEATS);

   logic [BEAT_W-1:0] beat_cnt_reg;
   logic [BEAT_W:0]   beat_num;
   logic              beat_acc;

   assign beat_acc = busy_w && mon_tvalid && mon_tready;
   assign beat_num = {1'b0, beat_cnt_reg} + (BEAT_W + 1)'(1);
   // tlast must land exactly on beat E; running past E is also a framing fault
   assign frame_err = beat_acc && (mon_tlast ? (beat_num != EXP_NUM) : (beat_num >= EXP_NUM));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_reg <= '0;
      end else if (abort || (idle_like && load_start)) begin
         beat_cnt_reg <= '0;
      end else if (beat_acc) begin
         beat_cnt_reg <= BEAT_W'(beat_num);
      end
   end

   assign error = (state_reg == S_ERROR);
`else
   logic unused_mon;
   assign unused_mon = ^{mon_tvalid, mon_tready, mon_tlast};
   assign frame_err  = 1'b0;
   assign error      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         tile_idx_reg <= '0;
         cfg_addr_reg <= '0;
         cfg_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         tile_idx_reg <= tile_idx_next;
         cfg_addr_reg <= cfg_addr_next;
         cfg_data_reg <= cfg_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tile_idx_next = tile_idx_reg;
      cfg_addr_next = cfg_addr_reg;
      cfg_data_next = cfg_data_reg;
      reader_start  = 1'b0;
      cfg_we        = 1'b0;
      case (state_reg)
         S_IDLE, S_DONE, S_ERROR: begin
            if (load_start) begin
               state_next    = S_START;
               tile_idx_next = '0;
            end
         end
         S_START: begin
            reader_start = 1'b1;
            state_next   = S_WAIT;
         end
         S_WAIT: begin
            if (reader_ready) begin
               cfg_data_next = reader_bits;
               cfg_addr_next = tile_idx_reg;
               state_next    = S_WRITE;
            end
         end
         S_WRITE: begin
            cfg_we = 1'b1;
            if (tile_idx_reg == LAST_TILE) begin
               state_next = S_DONE;
            end else begin
               tile_idx_next = tile_idx_reg + TILE_W'(1);
               state_next    = S_START;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (frame_err) begin
         state_next    = S_ERROR;
         cfg_we        = 1'b0;
         cfg_addr_next = cfg_addr_reg;
         cfg_data_next = cfg_data_reg;
      end
      // abort beats everything except reset, including a same-cycle load_start
      if (abort) begin
         state_next    = S_IDLE;
         tile_idx_next = tile_idx_reg;
         cfg_addr_next = cfg_addr_reg;
         cfg_data_next = cfg_data_reg;
         cfg_we        = 1'b0;
         reader_start  = 1'b0;
      end
      if (!rst_n) begin
         cfg_we       = 1'b0;
         reader_start = 1'b0;
      end
   end

   assign cfg_addr = cfg_addr_reg;
   assign cfg_data = cfg_data_reg;
   assign busy     = busy_w;
   assign done     = (state_reg == S_DONE);

endmodule

// File: tb/tb_bitstream_load_sequencer.sv
// Directed + randomized bench: emulates the reader (8 accepted beats per tile, then ready)
// and predicts writes/done/error from the framing rules.
module tb_bitstream_load_sequencer;

   localparam int NT = 4;
   localparam int CW = 8;
   localparam int E  = NT * CW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, load_start, abort, reader_ready;
   logic [CW-1:0] reader_bits;
   logic          mon_tvalid, mon_tready, mon_tlast;
   logic          reader_start, cfg_we, busy, done, error;
   logic [1:0]    cfg_addr;
   logic [CW-1:0] cfg_data;

   bitstream_load_sequencer #(.NUM_TILES(NT), .TILE_CFG_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
      .reader_start(reader_start), .reader_ready(reader_ready), .reader_bits(reader_bits),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   int            got_a[$];
   int            got_d[$];
   logic [CW-1:0] words[$];
   logic [CW-1:0] cur_word;
   int            n_starts, rd_left, beats_acc, tlast_at;
   bit            rd_fire, ready_now;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: first accepted beat that breaks framing (0 = well framed)
   function automatic int bad_beat(input int tl);
      if (tl == E) return 0;
      if (tl <= 0 || tl > E) return E;
      return tl;
   endfunction

   function automatic int exp_writes(input int tl);
`ifdef TLAST_CHECK_EN
      if (bad_beat(tl) != 0) return (bad_beat(tl) - 1) / CW;
`endif
      return NT;
   endfunction

   function automatic int exp_error(input int tl);
`ifdef TLAST_CHECK_EN
      return (bad_beat(tl) != 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // One clock: drive inputs at negedge, observe just after, before the consuming posedge
   task automatic cycle(input logic ls, input logic ab, input logic rn);
      @(negedge clk);
      load_start   = ls;
      abort        = ab;
      rst_n        = rn;
      reader_ready = 1'b0;
      mon_tvalid   = 1'b0;
      mon_tready   = 1'($urandom_range(0, 1));
      mon_tlast    = 1'b0;
      ready_now    = 1'b0;
      if (rd_fire) begin
         reader_ready = 1'b1;
         reader_bits  = cur_word;
         rd_fire      = 1'b0;
         ready_now    = 1'b1;
      end else if (rd_left > 0) begin
         mon_tvalid = ($urandom_range(0, 3) != 0);
         mon_tready = ($urandom_range(0, 3) != 0);
         mon_tlast  = mon_tvalid && (beats_acc + 1 == tlast_at);
         if (mon_tvalid && mon_tready) begin
            beats_acc++;
            rd_left--;
            if (rd_left == 0) rd_fire = 1'b1;
         end
      end
      #1;
      if (cfg_we) begin
         got_a.push_back(int'(cfg_addr));
         got_d.push_back(int'(cfg_data));
      end
      if (reader_start) begin
         rd_left  = CW;
         cur_word = (words.size() > n_starts) ? words[n_starts] : '0;
         n_starts++;
      end
   endtask

   task automatic begin_load(input int tl);
      got_a.delete();
      got_d.delete();
      words.delete();
      for (int i = 0; i < NT; i++) words.push_back(CW'($urandom_range(0, 255)));
      n_starts  = 0;
      rd_left   = 0;
      beats_acc = 0;
      rd_fire   = 1'b0;
      tlast_at  = tl;
   endtask

   task automatic start_load();
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
   endtask

   task automatic run_to_end(input string tag);
      for (int g = 0; g < 600 && busy; g++) cycle(1'b0, 1'b0, 1'b1);
      chk({tag, "_finished"}, busy, 1'b0);
      $display("load %s: writes=%0d done=%0b error=%0b", tag, got_a.size(), done, error);
   endtask

   task automatic check_writes(input string tag, input int exp_n);
      chk({tag, "_wr_count"}, got_a.size(), exp_n);
      for (int i = 0; i < got_a.size() && i < exp_n; i++) begin
         chk({tag, "_addr"}, got_a[i], i);
         chk({tag, "_data"}, got_d[i], int'(words[i]));
      end
   endtask

   initial begin
      rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; reader_ready = 1'b0; reader_bits = '0;
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      begin_load(E);

      // reset state
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_we", cfg_we, 0);
      chk("rst_rstart", reader_start, 0);
      chk("rst_addr", cfg_addr, 0);
      chk("rst_data", cfg_data, 0);

      // fixed words, full load
      begin_load(E);
      words = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
      start_load();
      chk("t1_busy", busy, 1);
      run_to_end("t1");
      check_writes("t1", NT);
      chk("t1_starts", n_starts, NT);
      chk("t1_done", done, 1);
      chk("t1_error", error, 0);
      chk("t1_addr_hold", cfg_addr, NT - 1);
      chk("t1_data_hold", cfg_data, 8'h01);

      // load_start during WAIT of tile 1 is ignored
      begin_load(E);
      start_load();
      for (int g = 0; g < 300 && n_starts < 2; g++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("t2_busy", busy, 1);
      run_to_end("t2");
      check_writes("t2", NT);
      chk("t2_done", done, 1);

      // abort during WAIT of tile 2
      begin_load(E);
      start_load();
      for (int g = 0; g < 300 && n_starts < 3; g++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t3_busy", busy, 0);
      chk("t3_done", done, 0);
      chk("t3_error", error, 0);
      repeat (60) cycle(1'b0, 1'b0, 1'b1);
      check_writes("t3", 2);
      $display("load t3: aborted after %0d writes", got_a.size());

      // reset during WRITE of tile 1
      begin_load(E);
      start_load();
      for (int g = 0; g < 300 && !(ready_now && n_starts == 2); g++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t4_we_in_rst", cfg_we, 0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t4_wr_count", got_a.size(), 1);
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_addr", cfg_addr, 0);
      chk("t4_data", cfg_data, 0);
      chk("t4_rstart", reader_start, 0);
      begin_load(E);
      start_load();
      run_to_end("t4r");
      check_writes("t4r", NT);

      // abort and load_start together from DONE: abort wins
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t7_busy", busy, 0);
      chk("t7_done", done, 0);

      // early tlast on beat 20, then no tlast on beat 32
      for (int k = 0; k < 2; k++) begin
         int tl;
         tl = (k == 0) ? 20 : 0;
         begin_load(tl);
         start_load();
         run_to_end((k == 0) ? "t5" : "t6");
         check_writes((k == 0) ? "t5" : "t6", exp_writes(tl));
         chk("tl_error", error, exp_error(tl));
         chk("tl_done", done, 1 - exp_error(tl));
         begin_load(E);
         start_load();
         chk("tl_err_clear", error, 0);
         chk("tl_restart_busy", busy, 1);
         run_to_end("tl_clean");
         check_writes("tl_clean", NT);
         chk("tl_clean_done", done, 1);
      end

      // randomized framing
      for (int r = 0; r < 6; r++) begin
         int sel, tl;
         sel = $urandom_range(0, 3);
         tl  = (sel == 1) ? 0 : (sel == 2) ? int'($urandom_range(1, E - 1)) : E;
         begin_load(tl);
         start_load();
         run_to_end("rand");
         check_writes("rand", exp_writes(tl));
         chk("rand_error", error, exp_error(tl));
         chk("rand_done", done, 1 - exp_error(tl));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
